tuner_ctrl: RTL and testbench
=============================

# tuner_ctrl

Link-side controller that drives the consumer end of the tuner search and lock handshakes, mirroring `tuner_phy`, which is the producer on both. It triggers a sweep, accepts the reported peak table and picks the strongest peak. It then hands that peak's power and tune codes to the lock engine, triggers lock and supervises tracking. On loss of lock or an empty sweep it re-searches, up to a bounded retry count. It sits between the system control plane (start/stop) and one `tuner_phy` instance per ring.

## Interface
Parameters:
- `DAC_WIDTH`, 8, ring tune code width
- `ADC_WIDTH`, 8, ring power code width
- `NUM_TARGET`, 8, peak table depth
- `MAX_RETRY`, 3, searches allowed per start before failing (≥1)
- `LOSS_THRES`, 16, consecutive cycles of `track_val` low that count as lock loss (≥1)

Ports:
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  single-cycle pulse; honoured only in IDLE or FAIL
- `i_stop`  in  1  single-cycle pulse; return to IDLE from any state
- `o_search_trig_val`  out  1  search request
- `i_search_trig_rdy`  in  1  search engine ready
- `i_search_peaks_val`  in  1  peak table valid
- `o_search_peaks_rdy`  out  1  ready to accept the peak table
- `i_search_ring_tune_peaks[NUM_TARGET]`  in  DAC_WIDTH each  tune code per peak
- `i_search_pwr_peaks[NUM_TARGET]`  in  ADC_WIDTH each  power code per peak
- `i_search_peaks_cnt`  in  $clog2(NUM_TARGET)+1  number of valid entries
- `o_lock_trig_val`  out  1  lock request
- `i_lock_trig_rdy`  in  1  lock engine ready
- `i_lock_track_val`  in  1  ring is locked and tracking
- `o_lock_track_rdy`  out  1  controller is supervising tracking
- `o_cfg_pwr_peak`  out  ADC_WIDTH  selected peak power; drives `tuner_phy` `i_cfg_pwr_peak`
- `o_cfg_ring_tune_peak`  out  DAC_WIDTH  selected peak tune code; drives `i_cfg_ring_tune_peak`
- `o_state`  out  3  state monitor
- `o_locked`  out  1  high in TRACK while `i_lock_track_val` is high
- `o_err`  out  1  high in FAIL
- `o_retry_cnt`  out  $clog2(MAX_RETRY+1)  searches started since the last start

## Operation
- States and encodings: IDLE=0, SEARCH_REQ=1, SEARCH_WAIT=2, SELECT=3, LOCK_REQ=4, TRACK=5, FAIL=6.
- IDLE → SEARCH_REQ on `i_start`; `o_retry_cnt` is cleared to 0.
- **SEARCH_REQ**
  - `o_search_trig_val`=1.
  - On `trig_val & trig_rdy`: `o_retry_cnt`+1, go to SEARCH_WAIT.
- **SEARCH_WAIT**
  - `o_search_peaks_rdy`=1.
  - On `peaks_val & peaks_rdy`: latch the table and count into internal registers, go to SELECT.
- **SELECT** (one cycle)
  - Scan entries with index < count; choose the maximum `pwr`. Ties go to the lowest index.
  - Count ≥1: load `o_cfg_*` with the chosen entry, go to LOCK_REQ.
  - Count =0: go to SEARCH_REQ if `o_retry_cnt` < MAX_RETRY, else FAIL.
  - A count above NUM_TARGET is clamped to NUM_TARGET.
- **LOCK_REQ**
  - `o_lock_trig_val`=1.
  - On `trig_val & trig_rdy`: go to TRACK and clear the loss counter.
- **TRACK**
  - `o_lock_track_rdy`=1.
  - Loss counter: cleared while `track_val`=1, incremented while it is 0.
  - When the counter reaches LOSS_THRES: go to SEARCH_REQ if `o_retry_cnt` < MAX_RETRY, else FAIL.
  - A successful lock does not reset `o_retry_cnt`; only `i_start` does.
- **FAIL**: `o_err`=1; `i_start` restarts as from IDLE.
- **`i_stop`**
  - Overrides every transition: next state is IDLE, all request and ready outputs drop the next cycle.
  - `o_cfg_*` hold their last values.
  - If `i_start` and `i_stop` arrive together, `i_stop` wins.
- Val/rdy handshake rules:
  - All val/rdy outputs are registered, decoded from the state register.
  - Once raised, a `val` is held until the handshake completes or `i_stop` arrives.

## Timing
- Reset values: state IDLE; every output 0, including `o_cfg_*`, `o_retry_cnt` and the internal peak registers.
- `i_start` at cycle t → `o_search_trig_val`=1 at t+1.
- Handshake at cycle t (`trig_val & trig_rdy`) → `trig_val`=0 at t+1; no duplicate triggers.
- Peak handshake at t:
  - SELECT at t+1.
  - `o_cfg_*` valid, and `o_lock_trig_val`=1, at t+2.
- `o_cfg_*` are stable through LOCK_REQ and TRACK; they change only in SELECT.
- Loss detection: after `track_val` falls at t with TRACK otherwise undisturbed, the state leaves TRACK at t+LOSS_THRES and `o_search_trig_val`=1 at t+LOSS_THRES+1.
- `o_locked` is registered: `i_lock_track_val` rising at t → `o_locked`=1 at t+1.
- Asynchronous reset mid-operation drops all outputs immediately; the controller restarts in IDLE.

## Test plan
- **Nominal lock**
  - Stimulus: start; table of 3 peaks, pwr {40,90,60}, tune {20,100,180}; track_val=1 after lock trigger.
  - Response: `o_cfg_pwr_peak`=90, `o_cfg_ring_tune_peak`=100; TRACK, `o_locked`=1, `o_retry_cnt`=1.
- **Tie and clamp**
  - Stimulus: pwr {70,70}, count=2; then count=12 with entry 7 the maximum.
  - Response: index 0 chosen; then index 7 chosen, with no out-of-range reads.
- **Empty sweep retry**
  - Stimulus: count=0 on every sweep with MAX_RETRY=3.
  - Response: exactly 3 search handshakes, then FAIL, `o_err`=1; `i_start` re-enters SEARCH_REQ with `o_retry_cnt`=0.
- **Lock loss**
  - Stimulus: in TRACK, track_val=0 for 15 cycles then 1.
  - Response: remains in TRACK.
  - Stimulus: track_val=0 for 16 cycles.
  - Response: re-search; `o_retry_cnt`=2.
- **Backpressure**
  - Stimulus: hold `trig_rdy`=0 for 10 cycles on both search and lock.
  - Response: `val` held constant; one handshake each when `rdy` rises.
- **Stop and reset**
  - Stimulus: `i_stop` during SEARCH_WAIT; separately `i_start`+`i_stop` in the same cycle; separately `i_rst_n` low mid-TRACK.
  - Response: IDLE at the next cycle with all val/rdy at 0; the simultaneous case stays in IDLE; reset gives all-zero outputs immediately.

Source files
------------

// File: rtl/tuner_ctrl.sv
// -----------------------------------------------------------------------------
// tuner_ctrl
//
// Link-side controller for one tuner_phy ring. It acts as the consumer on the
// search and lock handshakes: it triggers a sweep, takes the reported peak
// table, picks the strongest peak, hands that peak's codes to the lock engine,
// triggers lock and then watches tracking. Lock loss or an empty sweep starts
// a new search, up to MAX_RETRY searches per start.
//
// Ports
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start, i_stop            control-plane pulses (stop has priority)
//   o_search_trig_val / i_search_trig_rdy      search trigger handshake
//   i_search_peaks_val / o_search_peaks_rdy    peak table handshake
//   i_search_ring_tune_peaks, i_search_pwr_peaks, i_search_peaks_cnt
//                              peak table contents and valid entry count
//   o_lock_trig_val / i_lock_trig_rdy          lock trigger handshake
//   i_lock_track_val / o_lock_track_rdy        tracking supervision
//   o_cfg_pwr_peak, o_cfg_ring_tune_peak       selected peak codes to the phy
//   o_state, o_locked, o_err, o_retry_cnt      status monitors
// -----------------------------------------------------------------------------
module tuner_ctrl #(
    parameter int DAC_WIDTH  = 8,
    parameter int ADC_WIDTH  = 8,
    parameter int NUM_TARGET = 8,
    parameter int MAX_RETRY  = 3,
    parameter int LOSS_THRES = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic                            i_stop,
    output logic                            o_search_trig_val,
    input  logic                            i_search_trig_rdy,
    input  logic                            i_search_peaks_val,
    output logic                            o_search_peaks_rdy,
    input  logic [DAC_WIDTH-1:0]            i_search_ring_tune_peaks [NUM_TARGET],
    input  logic [ADC_WIDTH-1:0]            i_search_pwr_peaks [NUM_TARGET],
    input  logic [$clog2(NUM_TARGET):0]     i_search_peaks_cnt,
    output logic                            o_lock_trig_val,
    input  logic                            i_lock_trig_rdy,
    input  logic                            i_lock_track_val,
    output logic                            o_lock_track_rdy,
    output logic [ADC_WIDTH-1:0]            o_cfg_pwr_peak,
    output logic [DAC_WIDTH-1:0]            o_cfg_ring_tune_peak,
    output logic [2:0]                      o_state,
    output logic                            o_locked,
    output logic                            o_err,
    output logic [$clog2(MAX_RETRY+1)-1:0]  o_retry_cnt
);

    localparam int CNT_W   = $clog2(NUM_TARGET) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int LOSS_W  = $clog2(LOSS_THRES + 1);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SEARCH_REQ  = 3'd1,
        ST_SEARCH_WAIT = 3'd2,
        ST_SELECT      = 3'd3,
        ST_LOCK_REQ    = 3'd4,
        ST_TRACK       = 3'd5,
        ST_FAIL        = 3'd6
    } state_t;

    state_t               state_q, state_d;
    logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [LOSS_W-1:0]    loss_cnt_q, loss_cnt_d;
    logic [CNT_W-1:0]     peak_cnt_q, peak_cnt_d;
    logic [ADC_WIDTH-1:0] cfg_pwr_q, cfg_pwr_d;
    logic [DAC_WIDTH-1:0] cfg_tune_q, cfg_tune_d;

    logic search_trig_val_q;
    logic search_peaks_rdy_q;
    logic lock_trig_val_q;
    logic lock_track_rdy_q;
    logic locked_q;
    logic err_q;

    logic [DAC_WIDTH-1:0] tune_q [NUM_TARGET];
    logic [ADC_WIDTH-1:0] pwr_q  [NUM_TARGET];

    logic                 search_hs;
    logic                 peaks_hs;
    logic                 lock_hs;
    logic                 latch_peaks;
    logic                 retry_ok;
    logic [CNT_W-1:0]     cnt_clamped;
    logic [ADC_WIDTH-1:0] best_pwr;
    logic [DAC_WIDTH-1:0] best_tune;

    assign search_hs   = search_trig_val_q & i_search_trig_rdy;
    assign peaks_hs    = search_peaks_rdy_q & i_search_peaks_val;
    assign lock_hs     = lock_trig_val_q & i_lock_trig_rdy;
    assign latch_peaks = peaks_hs & ~i_stop;
    assign retry_ok    = (retry_cnt_q < RETRY_W'(MAX_RETRY));

    // A reported count larger than the table is limited to the table depth so
    // the selection scan never looks past the last entry.
    assign cnt_clamped = (i_search_peaks_cnt > CNT_W'(NUM_TARGET)) ?
                         CNT_W'(NUM_TARGET) : i_search_peaks_cnt;

    // Peak table storage, captured once per accepted table.
    generate
        for (genvar gi = 0; gi < NUM_TARGET; gi++) begin : g_peak
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    tune_q[gi] <= '0;
                    pwr_q[gi]  <= '0;
                end else if (latch_peaks) begin
                    tune_q[gi] <= i_search_ring_tune_peaks[gi];
                    pwr_q[gi]  <= i_search_pwr_peaks[gi];
                end
            end
        end
    endgenerate

    // Strongest-peak scan. Entry 0 is the starting candidate (only used when
    // the count is non-zero); a strict greater-than keeps ties on the lowest
    // index.
    always_comb begin
        best_pwr  = pwr_q[0];
        best_tune = tune_q[0];
        for (int i = 1; i < NUM_TARGET; i++) begin
            if ((CNT_W'(i) < peak_cnt_q) && (pwr_q[i] > best_pwr)) begin
                best_pwr  = pwr_q[i];
                best_tune = tune_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        peak_cnt_d  = peak_cnt_q;
        cfg_pwr_d   = cfg_pwr_q;
        cfg_tune_d  = cfg_tune_q;

        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (i_start) begin
                    state_d     = ST_SEARCH_REQ;
                    retry_cnt_d = '0;
                end
            end
            ST_SEARCH_REQ: begin
                if (search_hs) begin
                    state_d     = ST_SEARCH_WAIT;
                    retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                end
            end
            ST_SEARCH_WAIT: begin
                if (peaks_hs) begin
                    state_d    = ST_SELECT;
                    peak_cnt_d = cnt_clamped;
                end
            end
            ST_SELECT: begin
                if (peak_cnt_q != '0) begin
                    cfg_pwr_d  = best_pwr;
                    cfg_tune_d = best_tune;
                    state_d    = ST_LOCK_REQ;
                end else begin
                    state_d = retry_ok ? ST_SEARCH_REQ : ST_FAIL;
                end
            end
            ST_LOCK_REQ: begin
                if (lock_hs) begin
                    state_d    = ST_TRACK;
                    loss_cnt_d = '0;
                end
            end
            ST_TRACK: begin
                // The counter register holding LOSS_THRES is the loss event;
                // it is acted on the cycle after it is reached.
                if (loss_cnt_q == LOSS_W'(LOSS_THRES)) begin
                    state_d = retry_ok ? ST_SEARCH_REQ : ST_FAIL;
                end else if (i_lock_track_val) begin
                    loss_cnt_d = '0;
                end else begin
                    loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stop overrides every transition; the selected peak codes are kept.
        if (i_stop) begin
            state_d    = ST_IDLE;
            cfg_pwr_d  = cfg_pwr_q;
            cfg_tune_d = cfg_tune_q;
        end
    end

    // Single state register; all status and handshake outputs are registered
    // decodes of the next state so they line up with the state monitor.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q            <= ST_IDLE;
            retry_cnt_q        <= '0;
            loss_cnt_q         <= '0;
            peak_cnt_q         <= '0;
            cfg_pwr_q          <= '0;
            cfg_tune_q         <= '0;
            search_trig_val_q  <= 1'b0;
            search_peaks_rdy_q <= 1'b0;
            lock_trig_val_q    <= 1'b0;
            lock_track_rdy_q   <= 1'b0;
            locked_q           <= 1'b0;
            err_q              <= 1'b0;
        end else begin
            state_q            <= state_d;
            retry_cnt_q        <= retry_cnt_d;
            loss_cnt_q         <= loss_cnt_d;
            peak_cnt_q         <= peak_cnt_d;
            cfg_pwr_q          <= cfg_pwr_d;
            cfg_tune_q         <= cfg_tune_d;
            search_trig_val_q  <= (state_d == ST_SEARCH_REQ);
            search_peaks_rdy_q <= (state_d == ST_SEARCH_WAIT);
            lock_trig_val_q    <= (state_d == ST_LOCK_REQ);
            lock_track_rdy_q   <= (state_d == ST_TRACK);
            locked_q           <= (state_d == ST_TRACK) & i_lock_track_val;
            err_q              <= (state_d == ST_FAIL);
        end
    end

    assign o_search_trig_val    = search_trig_val_q;
    assign o_search_peaks_rdy   = search_peaks_rdy_q;
    assign o_lock_trig_val      = lock_trig_val_q;
    assign o_lock_track_rdy     = lock_track_rdy_q;
    assign o_cfg_pwr_peak       = cfg_pwr_q;
    assign o_cfg_ring_tune_peak = cfg_tune_q;
    assign o_state              = state_q;
    assign o_locked             = locked_q;
    assign o_err                = err_q;
    assign o_retry_cnt          = retry_cnt_q;

endmodule

// File: tb/tb_tuner_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tuner_ctrl
//
// Plays the tuner_phy side of both handshakes against tuner_ctrl. Expected
// values come from a transaction-level model: retry bookkeeping, strongest
// peak selection over the clamped table, and the cycle offsets of the timing
// rules. Directed scenarios are followed by randomized rounds.
// -----------------------------------------------------------------------------
module tb_tuner_ctrl;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int NT = 8;
    localparam int MR = 3;
    localparam int LT = 16;
    localparam int CW = $clog2(NT) + 1;
    localparam int RW = $clog2(MR + 1);

    localparam int S_IDLE = 0, S_SEARCH_REQ = 1, S_SEARCH_WAIT = 2, S_SELECT = 3;
    localparam int S_LOCK_REQ = 4, S_TRACK = 5, S_FAIL = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          s_trig_rdy = 1'b0;
    logic          s_peaks_val = 1'b0;
    logic          l_trig_rdy = 1'b0;
    logic          l_track_val = 1'b0;
    logic [DW-1:0] tune_in [NT];
    logic [AW-1:0] pwr_in  [NT];
    logic [CW-1:0] cnt_in = '0;

    logic          o_search_trig_val, o_search_peaks_rdy;
    logic          o_lock_trig_val, o_lock_track_rdy;
    logic [AW-1:0] o_cfg_pwr_peak;
    logic [DW-1:0] o_cfg_ring_tune_peak;
    logic [2:0]    o_state;
    logic          o_locked, o_err;
    logic [RW-1:0] o_retry_cnt;

    int checks = 0;
    int errors = 0;
    int srch_hs = 0;
    int lock_hs = 0;
    int exp_srch = 0;
    int exp_lock = 0;
    int exp_retry = 0;
    int exp_pwr = 0;
    int exp_tune = 0;

    tuner_ctrl #(
        .DAC_WIDTH(DW), .ADC_WIDTH(AW), .NUM_TARGET(NT),
        .MAX_RETRY(MR), .LOSS_THRES(LT)
    ) dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .i_start                  (start),
        .i_stop                   (stop),
        .o_search_trig_val        (o_search_trig_val),
        .i_search_trig_rdy        (s_trig_rdy),
        .i_search_peaks_val       (s_peaks_val),
        .o_search_peaks_rdy       (o_search_peaks_rdy),
        .i_search_ring_tune_peaks (tune_in),
        .i_search_pwr_peaks       (pwr_in),
        .i_search_peaks_cnt       (cnt_in),
        .o_lock_trig_val          (o_lock_trig_val),
        .i_lock_trig_rdy          (l_trig_rdy),
        .i_lock_track_val         (l_track_val),
        .o_lock_track_rdy         (o_lock_track_rdy),
        .o_cfg_pwr_peak           (o_cfg_pwr_peak),
        .o_cfg_ring_tune_peak     (o_cfg_ring_tune_peak),
        .o_state                  (o_state),
        .o_locked                 (o_locked),
        .o_err                    (o_err),
        .o_retry_cnt              (o_retry_cnt)
    );

    always #5 clk = ~clk;

    // Independent handshake counters, used to detect duplicate or missing triggers.
    always @(posedge clk) begin
        if (rst_n) begin
            if (o_search_trig_val && s_trig_rdy) srch_hs <= srch_hs + 1;
            if (o_lock_trig_val && l_trig_rdy)   lock_hs <= lock_hs + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference selection: strongest power among the first min(cnt, NT)
    // entries, earliest entry wins a tie.
    function automatic int pick_peak(input int n);
        int best = 0;
        for (int i = 1; i < n; i++) begin
            if (pwr_in[i] > pwr_in[best]) best = i;
        end
        return best;
    endfunction

    task automatic scramble();
        for (int i = 0; i < NT; i++) begin
            tune_in[i] = DW'($urandom);
            pwr_in[i]  = AW'($urandom);
        end
        cnt_in = CW'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_state"}, int'(o_state), S_IDLE);
        check_eq({tag, "_srch_val"}, int'(o_search_trig_val), 0);
        check_eq({tag, "_peaks_rdy"}, int'(o_search_peaks_rdy), 0);
        check_eq({tag, "_lock_val"}, int'(o_lock_trig_val), 0);
        check_eq({tag, "_track_rdy"}, int'(o_lock_track_rdy), 0);
        check_eq({tag, "_locked"}, int'(o_locked), 0);
        check_eq({tag, "_err"}, int'(o_err), 0);
        check_eq({tag, "_retry"}, int'(o_retry_cnt), 0);
        check_eq({tag, "_cfg_pwr"}, int'(o_cfg_pwr_peak), 0);
        check_eq({tag, "_cfg_tune"}, int'(o_cfg_ring_tune_peak), 0);
    endtask

    // After an empty sweep or a lock loss: re-search while searches remain.
    task automatic check_retry_outcome(input string tag);
        if (exp_retry < MR) begin
            check_eq({tag, "_research_state"}, int'(o_state), S_SEARCH_REQ);
            check_eq({tag, "_research_val"}, int'(o_search_trig_val), 1);
        end else begin
            check_eq({tag, "_fail_state"}, int'(o_state), S_FAIL);
            check_eq({tag, "_fail_err"}, int'(o_err), 1);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_retry = 0;
        check_eq("start_state", int'(o_state), S_SEARCH_REQ);
        check_eq("start_srch_val", int'(o_search_trig_val), 1);
        check_eq("start_retry", int'(o_retry_cnt), 0);
        check_eq("start_err", int'(o_err), 0);
        $display("txn start");
    endtask

    task automatic do_search(input int delay);
        check_eq("srch_val_up", int'(o_search_trig_val), 1);
        for (int d = 0; d < delay; d++) begin
            step();
            check_eq("srch_val_hold", int'(o_search_trig_val), 1);
        end
        s_trig_rdy = 1'b1;
        step();
        s_trig_rdy = 1'b0;
        exp_retry++;
        exp_srch++;
        check_eq("srch_val_drop", int'(o_search_trig_val), 0);
        check_eq("srch_wait_state", int'(o_state), S_SEARCH_WAIT);
        check_eq("srch_peaks_rdy", int'(o_search_peaks_rdy), 1);
        check_eq("srch_retry", int'(o_retry_cnt), exp_retry);
        check_eq("srch_hs_count", srch_hs, exp_srch);
        $display("txn search delay=%0d retry=%0d", delay, exp_retry);
    endtask

    task automatic do_table(input int delay, input int cnt);
        int n;
        int idx;
        for (int d = 0; d < delay; d++) begin
            step();
            check_eq("peaks_rdy_hold", int'(o_search_peaks_rdy), 1);
        end
        n = (cnt > NT) ? NT : cnt;
        if (n > 0) begin
            idx = pick_peak(n);
            exp_pwr  = int'(pwr_in[idx]);
            exp_tune = int'(tune_in[idx]);
        end
        cnt_in = CW'(cnt);
        s_peaks_val = 1'b1;
        step();
        s_peaks_val = 1'b0;
        scramble();
        check_eq("select_state", int'(o_state), S_SELECT);
        check_eq("select_rdy_drop", int'(o_search_peaks_rdy), 0);
        step();
        check_eq("cfg_pwr", int'(o_cfg_pwr_peak), exp_pwr);
        check_eq("cfg_tune", int'(o_cfg_ring_tune_peak), exp_tune);
        if (n > 0) begin
            check_eq("lockreq_state", int'(o_state), S_LOCK_REQ);
            check_eq("lockreq_val", int'(o_lock_trig_val), 1);
        end else begin
            check_retry_outcome("empty");
        end
        $display("txn table cnt=%0d pwr=%0d tune=%0d", cnt, exp_pwr, exp_tune);
    endtask

    task automatic do_lock(input int delay);
        for (int d = 0; d < delay; d++) begin
            step();
            check_eq("lock_val_hold", int'(o_lock_trig_val), 1);
        end
        l_trig_rdy = 1'b1;
        step();
        l_trig_rdy = 1'b0;
        exp_lock++;
        check_eq("lock_track_state", int'(o_state), S_TRACK);
        check_eq("lock_val_drop", int'(o_lock_trig_val), 0);
        check_eq("lock_track_rdy", int'(o_lock_track_rdy), 1);
        check_eq("lock_hs_count", lock_hs, exp_lock);
        $display("txn lock delay=%0d", delay);
    endtask

    task automatic do_track(input int cycles);
        l_track_val = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            step();
            check_eq("track_locked", int'(o_locked), 1);
            check_eq("track_state", int'(o_state), S_TRACK);
        end
        $display("txn track cycles=%0d", cycles);
    endtask

    // track_val low for 'low' cycles, then high again.
    task automatic do_loss(input int low);
        l_track_val = 1'b0;
        for (int k = 1; k <= low; k++) begin
            step();
            check_eq("loss_locked_low", int'(o_locked), 0);
            check_eq("loss_no_trig", int'(o_search_trig_val), 0);
            if (k < LT) check_eq("loss_in_track", int'(o_state), S_TRACK);
        end
        l_track_val = 1'b1;
        step();
        if (low >= LT) begin
            check_retry_outcome("loss");
            l_track_val = 1'b0;
        end else begin
            check_eq("loss_recover_state", int'(o_state), S_TRACK);
            check_eq("loss_recover_locked", int'(o_locked), 1);
        end
        $display("txn loss low=%0d", low);
    endtask

    initial begin
        int mode;
        int cnt;
        scramble();
        cnt_in = '0;

        // Reset state
        #3 rst_n = 1'b0;
        #1 check_all_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        check_all_zero("post_reset");

        // Nominal lock
        do_start();
        do_search(0);
        pwr_in[0] = 8'd40;  pwr_in[1] = 8'd90;  pwr_in[2] = 8'd60;
        tune_in[0] = 8'd20; tune_in[1] = 8'd100; tune_in[2] = 8'd180;
        for (int i = 3; i < NT; i++) pwr_in[i] = 8'd255;
        do_table(0, 3);
        check_eq("nominal_pwr_90", int'(o_cfg_pwr_peak), 90);
        check_eq("nominal_tune_100", int'(o_cfg_ring_tune_peak), 100);
        do_lock(0);
        do_track(3);
        check_eq("nominal_retry", int'(o_retry_cnt), 1);

        // Lock loss: 15 low cycles tolerated, 16 trigger a re-search
        do_loss(LT - 1);
        do_loss(LT);
        do_search(0);
        check_eq("loss_retry_2", int'(o_retry_cnt), 2);

        // Tie goes to the lowest index; entries past the count are ignored
        pwr_in[0] = 8'd70; pwr_in[1] = 8'd70; pwr_in[2] = 8'd250;
        tune_in[0] = 8'd11; tune_in[1] = 8'd22;
        do_table(0, 2);
        check_eq("tie_tune_idx0", int'(o_cfg_ring_tune_peak), 11);
        do_lock(1);
        do_track(2);
        do_loss(LT);
        do_search(1);

        // Count of 12 clamps to the 8-entry table; entry 7 is the maximum
        for (int i = 0; i < NT; i++) pwr_in[i] = AW'($urandom_range(0, 199));
        pwr_in[7] = 8'd200;
        tune_in[7] = 8'd77;
        do_table(1, 12);
        check_eq("clamp_tune_idx7", int'(o_cfg_ring_tune_peak), 77);
        do_lock(0);
        do_track(2);
        do_loss(LT);
        check_eq("third_loss_err", int'(o_err), 1);

        // Empty sweeps: exactly MR searches, then FAIL; start recovers
        do_start();
        for (int r = 0; r < MR; r++) begin
            do_search(0);
            do_table(0, 0);
        end
        check_eq("empty_fail_state", int'(o_state), S_FAIL);
        check_eq("empty_fail_err", int'(o_err), 1);
        do_start();

        // Backpressure on both trigger handshakes
        do_search(10);
        for (int i = 0; i < NT; i++) pwr_in[i] = AW'($urandom);
        do_table(2, 4);
        do_lock(10);
        do_track(2);

        // Stop from TRACK keeps the selected codes
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("stop_track_state", int'(o_state), S_IDLE);
        check_eq("stop_track_rdy", int'(o_lock_track_rdy), 0);
        check_eq("stop_track_locked", int'(o_locked), 0);
        check_eq("stop_cfg_pwr_hold", int'(o_cfg_pwr_peak), exp_pwr);
        check_eq("stop_cfg_tune_hold", int'(o_cfg_ring_tune_peak), exp_tune);
        l_track_val = 1'b0;

        // Stop during SEARCH_WAIT
        do_start();
        do_search(0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_eq("stop_wait_state", int'(o_state), S_IDLE);
        check_eq("stop_wait_rdy", int'(o_search_peaks_rdy), 0);
        check_eq("stop_wait_srch_val", int'(o_search_trig_val), 0);
        check_eq("stop_wait_lock_val", int'(o_lock_trig_val), 0);

        // Simultaneous start and stop: stop wins
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check_eq("startstop_state", int'(o_state), S_IDLE);
        check_eq("startstop_val", int'(o_search_trig_val), 0);
        step();
        check_eq("startstop_stays_idle", int'(o_state), S_IDLE);
        $display("txn stop checks done");

        // Randomized rounds against the model
        do_start();
        mode = S_SEARCH_REQ;
        for (int r = 0; r < 24; r++) begin
            if (mode == S_FAIL) begin
                check_eq("rnd_fail_err", int'(o_err), 1);
                do_start();
            end
            do_search(int'($urandom_range(0, 3)));
            for (int i = 0; i < NT; i++) begin
                tune_in[i] = DW'($urandom);
                pwr_in[i]  = AW'($urandom_range(0, 15));
            end
            cnt = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
            do_table(int'($urandom_range(0, 2)), cnt);
            if (cnt > 0) begin
                do_lock(int'($urandom_range(0, 3)));
                do_track(int'($urandom_range(1, 4)));
                if ($urandom_range(0, 1) == 1) do_loss(int'($urandom_range(1, LT - 1)));
                do_loss(LT);
            end
            mode = (exp_retry < MR) ? S_SEARCH_REQ : S_FAIL;
        end

        // Asynchronous reset in the middle of TRACK
        stop = 1'b1;
        step();
        stop = 1'b0;
        do_start();
        do_search(0);
        for (int i = 0; i < NT; i++) pwr_in[i] = AW'($urandom_range(1, 255));
        do_table(0, 3);
        do_lock(0);
        do_track(2);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        step();
        rst_n = 1'b1;
        l_track_val = 1'b0;
        exp_retry = 0;
        step();
        check_all_zero("after_async_reset");
        do_start();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
